// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the instruction-fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH     = 2'd0,
      WAIT_FULL = 2'd1,
      DRAIN     = 2'd2
   } fetch_state_e;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] PC_INCR          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + PC_INCR;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, PC} holding buffer that absorbs a fetched word while IF/ID is stalled.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_load,
   input  logic               i_drop,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [31:0]        i_pc,
   output logic [INSTR_W-1:0] o_instr,
   output logic [31:0]        o_pc,
   output logic               o_full
);

   logic [INSTR_W-1:0] r_instr;
   logic [31:0]        r_pc;
   logic               r_full;

   // Entry storage; a drop only clears the full flag, the stale payload is never observed
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_instr <= {INSTR_W{1'b0}};
         r_pc    <= 32'd0;
         r_full  <= 1'b0;
      end else if (i_load) begin
         r_instr <= i_instr;
         r_pc    <= i_pc;
         r_full  <= 1'b1;
      end else if (i_drop) begin
         r_full  <= 1'b0;
      end
   end

   assign o_instr = r_instr;
   assign o_pc    = r_pc;
   assign o_full  = r_full;

endmodule

// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, imem req/ready FSM, skid buffer and IF/ID register.
// Optional fetch/flush event counters are built when PC_FETCH_PERF_CNT_EN is defined.
module pc_fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [31:0]        i_nextPC,
   input  logic               i_jumpTaken,
   input  logic               i_stall,
   output logic [31:0]        o_pcPlusFour,
   output logic [31:0]        o_PC,
   output logic               o_imemReq,
   output logic [31:0]        o_imemAddr,
   input  logic               i_imemReady,
   input  logic [INSTR_W-1:0] i_imemData,
   output logic [INSTR_W-1:0] o_instr,
   output logic [31:0]        o_instrPC,
   output logic               o_instrValid
`ifdef PC_FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        o_fetchCount,
   output logic [31:0]        o_flushCount
`endif
);

   fetch_state_e       r_state;
   fetch_state_e       w_state_nxt;
   logic [31:0]        r_pc;
   logic [31:0]        w_pc_nxt;
   logic [31:0]        r_pend_pc;
   logic [31:0]        w_pend_nxt;
   logic [INSTR_W-1:0] r_instr;
   logic [INSTR_W-1:0] w_ifid_instr;
   logic [INSTR_W-1:0] w_skid_instr;
   logic [31:0]        r_instr_pc;
   logic [31:0]        w_ifid_pc;
   logic [31:0]        w_skid_pc;
   logic               r_instr_valid;
   logic               w_ifid_load;
   logic               w_ifid_clear;
   logic               w_skid_load;
   logic               w_skid_drop;
   logic               w_skid_full;
   logic               w_imem_req;
   logic               w_handshake;

   assign w_imem_req  = !i_rst && (r_state != WAIT_FULL);
   assign w_handshake = w_imem_req && i_imemReady;

   fetch_skid_buf u_skid (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_skid_load),
      .i_drop  (w_skid_drop),
      .i_instr (i_imemData),
      .i_pc    (r_pc),
      .o_instr (w_skid_instr),
      .o_pc    (w_skid_pc),
      .o_full  (w_skid_full)
   );

   // Next-state and datapath control; jumpTaken outranks stall in every state
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_pend_nxt   = r_pend_pc;
      w_ifid_load  = 1'b0;
      w_ifid_clear = 1'b0;
      w_ifid_instr = i_imemData;
      w_ifid_pc    = r_pc;
      w_skid_load  = 1'b0;
      w_skid_drop  = 1'b0;
      case (r_state)
         FETCH: begin
            if (i_jumpTaken) begin
               w_ifid_clear = 1'b1;
               if (w_handshake) begin
                  w_pc_nxt = i_nextPC;
               end else begin
                  w_pend_nxt  = i_nextPC;
                  w_state_nxt = DRAIN;
               end
            end else if (w_handshake) begin
               w_pc_nxt = i_nextPC;
               if (i_stall) begin
                  w_skid_load = 1'b1;
                  w_state_nxt = WAIT_FULL;
               end else begin
                  w_ifid_load = 1'b1;
               end
            end else if (!i_stall) begin
               w_ifid_clear = 1'b1;
            end else begin
               w_ifid_clear = 1'b0;
            end
         end
         WAIT_FULL: begin
            w_ifid_instr = w_skid_instr;
            w_ifid_pc    = w_skid_pc;
            if (i_jumpTaken) begin
               w_skid_drop  = 1'b1;
               w_ifid_clear = 1'b1;
               w_pc_nxt     = i_nextPC;
               w_state_nxt  = FETCH;
            end else if (!i_stall && w_skid_full) begin
               w_skid_drop = 1'b1;
               w_ifid_load = 1'b1;
               w_state_nxt = FETCH;
            end else begin
               w_skid_drop = 1'b0;
            end
         end
         DRAIN: begin
            // The old request is still in flight at r_pc; the newest redirect target wins
            w_ifid_clear = 1'b1;
            if (w_handshake) begin
               w_pc_nxt    = i_jumpTaken ? i_nextPC : r_pend_pc;
               w_state_nxt = FETCH;
            end else if (i_jumpTaken) begin
               w_pend_nxt = i_nextPC;
            end else begin
               w_pend_nxt = r_pend_pc;
            end
         end
         default: begin
            w_state_nxt = FETCH;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // PC, pending redirect target and IF/ID register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc          <= RESET_PC;
         r_pend_pc     <= 32'd0;
         r_instr       <= {INSTR_W{1'b0}};
         r_instr_pc    <= 32'd0;
         r_instr_valid <= 1'b0;
      end else begin
         r_pc      <= w_pc_nxt;
         r_pend_pc <= w_pend_nxt;
         if (w_ifid_load) begin
            r_instr       <= w_ifid_instr;
            r_instr_pc    <= w_ifid_pc;
            r_instr_valid <= 1'b1;
         end else if (w_ifid_clear) begin
            r_instr_valid <= 1'b0;
         end
      end
   end

   assign o_pcPlusFour = pc_inc(r_pc);
   assign o_PC         = r_pc;
   assign o_imemReq    = w_imem_req;
   assign o_imemAddr   = r_pc;
   assign o_instr      = r_instr;
   assign o_instrPC    = r_instr_pc;
   assign o_instrValid = r_instr_valid;

`ifdef PC_FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_flush_cnt;

   // Event counters, wrapping silently at 2^32
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fetch_cnt <= 32'd0;
         r_flush_cnt <= 32'd0;
      end else begin
         if (w_ifid_load) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
         if (i_jumpTaken) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
         end
      end
   end

   assign o_fetchCount = r_fetch_cnt;
   assign o_flushCount = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios plus a randomized run
// against a transaction-level reference model (queue-based skid, redirect bookkeeping).
module tb_pc_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [31:0] i_nextPC = 32'd0;
   logic        i_jumpTaken = 1'b0;
   logic        i_stall = 1'b0;
   logic        i_imemReady = 1'b0;
   logic [31:0] i_imemData = 32'd0;
   logic [31:0] o_pcPlusFour;
   logic [31:0] o_PC;
   logic        o_imemReq;
   logic [31:0] o_imemAddr;
   logic [31:0] o_instr;
   logic [31:0] o_instrPC;
   logic        o_instrValid;
`ifdef PC_FETCH_PERF_CNT_EN
   logic [31:0] o_fetchCount;
   logic [31:0] o_flushCount;
   logic [31:0] m_fc;
   logic [31:0] m_flc;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] m_pc, m_instr, m_ipc, m_target;
   logic        m_valid, m_drain;
   logic [63:0] m_skid[$];

   // Comb outputs sampled just before the edge, and what the model expects of them
   logic        pre_req, exp_req;
   logic [31:0] pre_addr, exp_addr, pre_p4, exp_p4;

   always #5 clk = ~clk;

   pc_fetch_stage #(.RESET_PC(RST_PC)) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_nextPC     (i_nextPC),
      .i_jumpTaken  (i_jumpTaken),
      .i_stall      (i_stall),
      .o_pcPlusFour (o_pcPlusFour),
      .o_PC         (o_PC),
      .o_imemReq    (o_imemReq),
      .o_imemAddr   (o_imemAddr),
      .i_imemReady  (i_imemReady),
      .i_imemData   (i_imemData),
      .o_instr      (o_instr),
      .o_instrPC    (o_instrPC),
      .o_instrValid (o_instrValid)
`ifdef PC_FETCH_PERF_CNT_EN
      ,
      .o_fetchCount (o_fetchCount),
      .o_flushCount (o_flushCount)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   // One clock cycle: drive inputs, sample comb outputs, advance the model, pass the edge
   task automatic step(input logic r, input logic j, input logic [31:0] tgt,
                       input logic s, input logic rdy);
      logic [63:0] w;
      @(negedge clk);
      i_rst       = r;
      i_jumpTaken = j;
      i_stall     = s;
      i_imemReady = rdy;
      i_nextPC    = j ? tgt : m_pc + 32'd4;
      i_imemData  = mem_word(m_pc);
      #1;
      pre_req  = o_imemReq;
      pre_addr = o_imemAddr;
      pre_p4   = o_pcPlusFour;
      exp_req  = !r && (m_skid.size() == 0);
      exp_addr = m_pc;
      exp_p4   = m_pc + 32'd4;
      if (r) begin
         m_pc = RST_PC; m_instr = 32'd0; m_ipc = 32'd0; m_valid = 1'b0;
         m_drain = 1'b0; m_target = 32'd0; m_skid.delete();
`ifdef PC_FETCH_PERF_CNT_EN
         m_fc = 32'd0; m_flc = 32'd0;
`endif
      end else begin
`ifdef PC_FETCH_PERF_CNT_EN
         if (j) m_flc = m_flc + 32'd1;
`endif
         if (m_drain) begin
            if (j) m_target = tgt;
            if (rdy) begin
               m_pc = m_target;
               m_drain = 1'b0;
            end
         end else if (m_skid.size() != 0) begin
            if (j) begin
               m_skid.delete();
               m_valid = 1'b0;
               m_pc = tgt;
            end else if (!s) begin
               w = m_skid.pop_front();
               m_instr = w[63:32]; m_ipc = w[31:0]; m_valid = 1'b1;
`ifdef PC_FETCH_PERF_CNT_EN
               m_fc = m_fc + 32'd1;
`endif
            end
         end else if (j) begin
            m_valid = 1'b0;
            if (rdy) m_pc = tgt;
            else begin
               m_drain = 1'b1;
               m_target = tgt;
            end
         end else if (rdy) begin
            if (s) m_skid.push_back({mem_word(m_pc), m_pc});
            else begin
               m_instr = mem_word(m_pc); m_ipc = m_pc; m_valid = 1'b1;
`ifdef PC_FETCH_PERF_CNT_EN
               m_fc = m_fc + 32'd1;
`endif
            end
            m_pc = m_pc + 32'd4;
         end else if (!s) begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      n_checks++; if (o_PC !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %h exp %h", o_PC, RST_PC); end
      n_checks++; if (o_instrValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", o_instrValid); end
      n_checks++; if ({o_instr, o_instrPC} !== 64'd0) begin n_fail++; $display("FAIL reset_ifid got %h/%h exp 0/0", o_instr, o_instrPC); end
      n_checks++; if (o_imemReq !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", o_imemReq); end
`ifdef PC_FETCH_PERF_CNT_EN
      n_checks++; if ({o_fetchCount, o_flushCount} !== 64'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", o_fetchCount, o_flushCount); end
`endif
   endtask

   task automatic test_sequential();
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
         n_checks++; if (pre_req !== 1'b1 || pre_addr !== RST_PC + 32'(4 * k)) begin n_fail++; $display("FAIL seq_addr%0d got %b/%h exp 1/%h", k, pre_req, pre_addr, RST_PC + 32'(4 * k)); end
         n_checks++; if (o_instrValid !== 1'b1 || o_instrPC !== RST_PC + 32'(4 * k) || o_instr !== mem_word(RST_PC + 32'(4 * k))) begin n_fail++; $display("FAIL seq_ifid%0d got %b/%h/%h", k, o_instrValid, o_instrPC, o_instr); end
      end
   endtask

   task automatic test_stall_skid();
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      n_checks++; if (o_PC !== 32'h108 || o_instrPC !== 32'h100 || o_instrValid !== 1'b1) begin n_fail++; $display("FAIL skid_hold got pc %h ipc %h v %b exp 108/100/1", o_PC, o_instrPC, o_instrValid); end
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
         n_checks++; if (pre_req !== 1'b0) begin n_fail++; $display("FAIL skid_req_low%0d got %b exp 0", k, pre_req); end
      end
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      n_checks++; if (pre_req !== 1'b0) begin n_fail++; $display("FAIL skid_release_req got %b exp 0", pre_req); end
      n_checks++; if (o_instrPC !== 32'h104 || o_instr !== mem_word(32'h104) || o_instrValid !== 1'b1) begin n_fail++; $display("FAIL skid_deliver got %h/%h/%b exp 104", o_instrPC, o_instr, o_instrValid); end
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      n_checks++; if (pre_req !== 1'b1 || pre_addr !== 32'h108 || o_instrPC !== 32'h108) begin n_fail++; $display("FAIL skid_resume got %b/%h ipc %h exp 1/108/108", pre_req, pre_addr, o_instrPC); end
   endtask

   task automatic test_jump_drain();
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'h400, 1'b0, 1'b0);
      n_checks++; if (o_instrValid !== 1'b0 || o_PC !== 32'h104) begin n_fail++; $display("FAIL drain_enter got v %b pc %h exp 0/104", o_instrValid, o_PC); end
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      n_checks++; if (pre_req !== 1'b1 || pre_addr !== 32'h104 || o_instrValid !== 1'b0) begin n_fail++; $display("FAIL drain_hold got %b/%h v %b exp 1/104/0", pre_req, pre_addr, o_instrValid); end
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      n_checks++; if (pre_addr !== 32'h104 || o_PC !== 32'h400 || o_instrValid !== 1'b0) begin n_fail++; $display("FAIL drain_done got addr %h pc %h v %b exp 104/400/0", pre_addr, o_PC, o_instrValid); end
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      n_checks++; if (pre_addr !== 32'h400 || o_instrPC !== 32'h400 || o_instrValid !== 1'b1) begin n_fail++; $display("FAIL drain_target got addr %h ipc %h v %b exp 400/400/1", pre_addr, o_instrPC, o_instrValid); end
   endtask

   task automatic test_double_jump();
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'h400, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h800, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      n_checks++; if (pre_addr !== 32'h104 || o_PC !== 32'h800) begin n_fail++; $display("FAIL dbl_jump got addr %h pc %h exp 104/800", pre_addr, o_PC); end
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      n_checks++; if (pre_addr !== 32'h800) begin n_fail++; $display("FAIL dbl_jump_req got %h exp 800", pre_addr); end
   endtask

   task automatic test_wrap();
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      n_checks++; if (pre_addr !== 32'hFFFF_FFFC || pre_p4 !== 32'd0) begin n_fail++; $display("FAIL wrap_p4 got addr %h p4 %h exp fffffffc/0", pre_addr, pre_p4); end
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      n_checks++; if (pre_addr !== 32'd0 || o_instrPC !== 32'd0) begin n_fail++; $display("FAIL wrap_next got addr %h ipc %h exp 0/0", pre_addr, o_instrPC); end
   endtask

   task automatic test_reset_in_drain();
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'h400, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
      n_checks++; if (o_imemReq !== 1'b0 || o_PC !== RST_PC || o_instrValid !== 1'b0) begin n_fail++; $display("FAIL rst_drain got req %b pc %h v %b exp 0/%h/0", o_imemReq, o_PC, o_instrValid, RST_PC); end
`ifdef PC_FETCH_PERF_CNT_EN
      n_checks++; if ({o_fetchCount, o_flushCount} !== 64'd0) begin n_fail++; $display("FAIL rst_drain_cnt got %0d/%0d exp 0/0", o_fetchCount, o_flushCount); end
`endif
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      n_checks++; if (pre_req !== 1'b1 || pre_addr !== RST_PC || o_PC !== RST_PC + 32'd4) begin n_fail++; $display("FAIL rst_drain_restart got %b/%h pc %h", pre_req, pre_addr, o_PC); end
   endtask

   task automatic test_random();
      logic r, j, s, rdy;
      logic [31:0] tgt;
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
      for (int k = 0; k < 600; k++) begin
         r   = ($urandom_range(0, 99) < 2);
         j   = ($urandom_range(0, 7) == 0);
         s   = ($urandom_range(0, 2) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         tgt = $urandom() & 32'hFFFF_FFFC;
         step(r, j, tgt, s, rdy);
         n_checks++; if (pre_req !== exp_req) begin n_fail++; $display("FAIL rnd_req c%0d got %b exp %b", k, pre_req, exp_req); end
         if (exp_req) begin
            n_checks++; if (pre_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr c%0d got %h exp %h", k, pre_addr, exp_addr); end
         end
         n_checks++; if (pre_p4 !== exp_p4) begin n_fail++; $display("FAIL rnd_p4 c%0d got %h exp %h", k, pre_p4, exp_p4); end
         n_checks++; if (o_PC !== m_pc) begin n_fail++; $display("FAIL rnd_pc c%0d got %h exp %h", k, o_PC, m_pc); end
         n_checks++; if (o_instrValid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c%0d got %b exp %b", k, o_instrValid, m_valid); end
         n_checks++; if (o_instr !== m_instr || o_instrPC !== m_ipc) begin n_fail++; $display("FAIL rnd_ifid c%0d got %h/%h exp %h/%h", k, o_instr, o_instrPC, m_instr, m_ipc); end
`ifdef PC_FETCH_PERF_CNT_EN
         n_checks++; if (o_fetchCount !== m_fc || o_flushCount !== m_flc) begin n_fail++; $display("FAIL rnd_cnt c%0d got %0d/%0d exp %0d/%0d", k, o_fetchCount, o_flushCount, m_fc, m_flc); end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall_skid();
      test_jump_drain();
      test_double_jump();
      test_wrap();
      test_reset_in_drain();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
